// File: rtl/ifu_fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int InstBusW     = 32;
  localparam int InstAddrBusW = 32;

  localparam logic [InstBusW-1:0]     ZeroInst       = '0;
  localparam logic [InstAddrBusW-1:0] ZeroInstAddr   = '0;
  localparam logic [InstAddrBusW-1:0] ResetPcDefault = 32'h0000_0000;

  // Instruction bus interface widths
  localparam int IbusDataW = InstBusW;
  localparam int IbusAddrW = InstAddrBusW;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request on the bus, waiting for grant
    S_WAIT = 2'd1,  // granted, waiting for read data
    S_BUF  = 2'd2   // one response parked in the skid buffer during a stall
  } fetch_state_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry {inst, addr} holding register used while downstream is stalled.
module ifu_skid_buf
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W = InstAddrBusW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic                clr_i,
  input  logic [InstBusW-1:0] inst_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic                valid_o,
  output logic [InstBusW-1:0] inst_o,
  output logic [ADDR_W-1:0]   addr_o
);

  logic                valid_q;
  logic [InstBusW-1:0] inst_q;
  logic [ADDR_W-1:0]   addr_q;

  // Clear wins over write; data is only meaningful while valid_q is set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      inst_q  <= ZeroInst;
      addr_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      inst_q  <= inst_i;
      addr_q  <= addr_i;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: keeps the PC, issues one read at a time on the
// instruction bus and feeds the IF/ID register with {inst, addr, valid}.
//
// Bus handshake: ibus_req_o/ibus_addr_o are held stable from assertion until
// the cycle ibus_gnt_i is sampled high; that cycle transfers the request.
// Exactly one read is outstanding after a grant, and its data is returned on
// the single cycle ibus_rvalid_i is high (no earlier than the cycle after gnt).
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBusW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ResetPcDefault)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 jump_flag_i,
  input  logic [ADDR_W-1:0]    jump_addr_i,
  input  logic                 hold_i,
  output logic                 ibus_req_o,
  output logic [ADDR_W-1:0]    ibus_addr_o,
  input  logic                 ibus_gnt_i,
  input  logic                 ibus_rvalid_i,
  input  logic [IbusDataW-1:0] ibus_rdata_i,
  output logic [InstBusW-1:0]  inst_o,
  output logic [ADDR_W-1:0]    inst_addr_o,
  output logic                 inst_valid_o
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                discard_q, discard_d;
  logic [InstBusW-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic                valid_q, valid_d;

  logic                buf_wr, buf_clr, buf_valid;
  logic [InstBusW-1:0] buf_inst;
  logic [ADDR_W-1:0]   buf_addr;
  logic [ADDR_W-1:0]   jump_pc;

  assign jump_pc = {jump_addr_i[ADDR_W-1:2], 2'b00};

  ifu_skid_buf #(.ADDR_W(ADDR_W)) u_skid_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (buf_wr),
    .clr_i   (buf_clr),
    .inst_i  (ibus_rdata_i),
    .addr_i  (req_addr_q),
    .valid_o (buf_valid),
    .inst_o  (buf_inst),
    .addr_o  (buf_addr)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      discard_q   <= 1'b0;
      inst_q      <= ZeroInst;
      inst_addr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      discard_q   <= discard_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state, PC, discard and IF/ID output selection; jump beats hold and rvalid.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    discard_d   = discard_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    buf_wr      = 1'b0;
    buf_clr     = 1'b0;

    if (jump_flag_i) begin
      pc_d    = jump_pc;
      valid_d = 1'b0;
      inst_d  = ZeroInst;
      buf_clr = 1'b1;
      unique case (state_q)
        S_REQ: begin
          // The pending request still completes; its data must be dropped.
          discard_d = 1'b1;
          if (ibus_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      // Without a stall the IF/ID register consumes every cycle: bubble by default.
      if (!hold_i) begin
        valid_d = 1'b0;
        inst_d  = ZeroInst;
      end
      unique case (state_q)
        S_REQ: begin
          if (ibus_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (!hold_i || !valid_q) begin
              inst_d      = ibus_rdata_i;
              inst_addr_d = req_addr_q;
              valid_d     = 1'b1;
              pc_d        = req_addr_q + ADDR_W'(4);
              state_d     = S_REQ;
            end else begin
              buf_wr  = 1'b1;
              pc_d    = req_addr_q + ADDR_W'(4);
              state_d = S_BUF;
            end
          end
        end
        S_BUF: begin
          if (!hold_i) begin
            inst_d      = buf_inst;
            inst_addr_d = buf_addr;
            valid_d     = buf_valid;
            buf_clr     = 1'b1;
            state_d     = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    // The request address is captured only when a new request starts.
    if (state_q != S_REQ && state_d == S_REQ) req_addr_d = pc_d;
  end

  assign ibus_req_o   = (state_q == S_REQ) && !rst_i;
  assign ibus_addr_o  = req_addr_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bus responder, reference output model, scoreboard.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_i        (hold_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];          // {addr, inst} responses not yet shown on the outputs
  logic [31:0] exp_pc;            // address the next request must use
  logic [31:0] exp_req;           // address of the request currently on the bus
  logic        prev_req;
  logic        m_valid;
  logic [31:0] m_inst, m_addr;

  // responder state
  logic        pend_valid, pend_stale, req_stale, ghost;
  logic [31:0] pend_addr, pend_data;
  int          pend_wait, req_wait, gnt_need;
  int          gnt_lo, gnt_hi, rsp_lo, rsp_hi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0000_0013;
    else if (a == 32'h4) return 32'h0010_0093;
    else                 return (a ^ 32'hA5A5_0000) + 32'h0000_0033;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: bus-side checks, responder, model update, edge, output checks.
  task automatic tick();
    logic [63:0] e;
    logic        rsp_now;
    if (ibus_req_o) begin
      if (!prev_req) exp_req = exp_pc;
      check_eq("req_addr", ibus_addr_o, exp_req);
    end
    if (pend_valid || exp_q.size() != 0) check_eq("req_idle", ibus_req_o, 0);
    prev_req = ibus_req_o;

    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;
    rsp_now       = 1'b0;
    if (ghost) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = 32'hDEAD_BEEF;
      ghost         = 1'b0;
    end else if (pend_valid) begin
      if (pend_wait == 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = pend_data;
        rsp_now       = 1'b1;
      end
    end else if (ibus_req_o && req_wait >= gnt_need) begin
      ibus_gnt_i = 1'b1;
    end

    if (jump_flag_i) begin
      exp_q.delete();
      exp_pc = {jump_addr_i[31:2], 2'b00};
    end
    if (rsp_now) begin
      pend_valid = 1'b0;
      if (!pend_stale && !jump_flag_i) begin
        exp_q.push_back({pend_addr, mem_word(pend_addr)});
        exp_pc = pend_addr + 32'd4;
      end
    end else if (pend_valid) begin
      pend_wait--;
      if (jump_flag_i) pend_stale = 1'b1;
    end else if (ibus_gnt_i) begin
      pend_valid = 1'b1;
      pend_addr  = exp_req;
      pend_data  = mem_word(ibus_addr_o);
      pend_stale = req_stale | jump_flag_i;
      pend_wait  = int'($urandom_range(rsp_hi - 1, rsp_lo - 1));
      req_stale  = 1'b0;
      req_wait   = 0;
      gnt_need   = int'($urandom_range(gnt_hi, gnt_lo));
    end else if (ibus_req_o) begin
      req_wait++;
      if (jump_flag_i) req_stale = 1'b1;
    end

    if (jump_flag_i) begin
      m_valid = 1'b0;
      m_inst  = 32'h0;
    end else if (hold_i && m_valid) begin
      // frozen; any arriving response stays queued
    end else if (exp_q.size() != 0) begin
      e       = exp_q.pop_front();
      m_addr  = e[63:32];
      m_inst  = e[31:0];
      m_valid = 1'b1;
    end else if (!hold_i) begin
      m_valid = 1'b0;
      m_inst  = 32'h0;
    end

    @(posedge clk_i);
    #1;
    check_eq("inst_valid", inst_valid_o, m_valid);
    check_eq("inst", inst_o, m_inst);
    check_eq("inst_addr", inst_addr_o, m_addr);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tick_until_pend(input int max_cycles);
    for (int i = 0; i < max_cycles && !pend_valid; i++) tick();
    check_eq("pend_timeout", pend_valid, 1);
  endtask

  task automatic tick_until_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && !m_valid; i++) tick();
    check_eq("valid_timeout", inst_valid_o, 1);
  endtask

  task automatic jump_pulse(input logic [31:0] target);
    jump_flag_i = 1'b1;
    jump_addr_i = target;
    tick();
    jump_flag_i = 1'b0;
  endtask

  // Reset asserted between edges to show it acts asynchronously.
  task automatic do_reset();
    #2;
    rst_i       = 1'b1;
    jump_flag_i = 1'b0;
    hold_i      = 1'b0;
    ibus_gnt_i  = 1'b0;
    ibus_rvalid_i = 1'b0;
    #1;
    check_eq("rst_valid", inst_valid_o, 0);
    check_eq("rst_inst", inst_o, 32'h0);
    check_eq("rst_inst_addr", inst_addr_o, 32'h0);
    check_eq("rst_req", ibus_req_o, 0);
    check_eq("rst_bus_addr", ibus_addr_o, RESET_PC);
    exp_q.delete();
    exp_pc     = RESET_PC;
    exp_req    = RESET_PC;
    prev_req   = 1'b0;
    m_valid    = 1'b0;
    m_inst     = 32'h0;
    m_addr     = 32'h0;
    pend_valid = 1'b0;
    pend_stale = 1'b0;
    req_stale  = 1'b0;
    req_wait   = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
    ghost = 1'b0; pend_wait = 0; gnt_need = 0;
    gnt_lo = 0; gnt_hi = 0; rsp_lo = 1; rsp_hi = 1;
    pend_addr = 32'h0; pend_data = 32'h0;
    do_reset();

    // zero-wait memory: 0x0, 0x4, 0x8 with valid alternating
    ticks(8);

    // grant delayed by three cycles
    gnt_lo = 3; gnt_hi = 3;
    gnt_need = 3;
    ticks(12);
    gnt_lo = 0; gnt_hi = 0; gnt_need = 0;

    // hold for four cycles with a valid instruction on the outputs
    tick_until_valid(10);
    hold_i = 1'b1;
    ticks(4);
    hold_i = 1'b0;
    ticks(4);

    // jump while waiting for read data (misaligned target is word-aligned)
    rsp_lo = 2; rsp_hi = 2;
    tick_until_pend(10);
    jump_pulse(32'h0000_0103);
    ticks(8);

    // jump in the same cycle as rvalid
    rsp_lo = 1; rsp_hi = 1;
    tick_until_pend(10);
    jump_pulse(32'h0000_0200);
    ticks(6);

    // PC wrap at the top of the address space
    tick_until_pend(10);
    jump_pulse(32'hFFFF_FFFE);
    ticks(10);

    // jump while the request is still waiting for grant
    gnt_lo = 2; gnt_hi = 2;
    tick_until_valid(20);
    tick();
    jump_pulse(32'h0000_0400);
    gnt_lo = 0; gnt_hi = 0;
    ticks(10);

    // async reset mid-wait, then a late response that must be ignored
    rsp_lo = 3; rsp_hi = 3;
    tick_until_pend(10);
    do_reset();
    ghost = 1'b1;
    ticks(8);

    // randomized traffic
    gnt_lo = 0; gnt_hi = 2; rsp_lo = 1; rsp_hi = 3;
    for (int i = 0; i < 400; i++) begin
      hold_i      = ($urandom_range(3, 0) == 0);
      jump_flag_i = ($urandom_range(19, 0) == 0);
      jump_addr_i = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(32'hFFFF, 0));
      tick();
    end
    jump_flag_i = 1'b0;
    hold_i      = 1'b0;
    ticks(12);
    check_eq("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", $time, 200000);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
